// File: rtl/dsd_mem_pkg.sv
// dsd_mem_pkg: shared types and constants for the data-memory arbiter
package dsd_mem_pkg;
    typedef enum logic [1:0] {RR, LOCK, FORCE_C} arb_state_t;
    typedef enum logic {PORT_C, PORT_E} arb_port_t;
    localparam int DMEM_RD_LAT = 1;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports C/E plus the dmem side of the arbiter
// slave  : arbiter view (requests and mem_rdata in; grants, read returns, mem strobes, stats out)
// master : requester/memory view (mirror of slave)
interface dmem_arbiter_if #(parameter int AW = 16, parameter int DW = 16);
    logic          c_req, c_wr, e_req, e_wr, e_lock;
    logic [AW-1:0] c_addr, e_addr, mem_addr;
    logic [DW-1:0] c_wdata, e_wdata, c_rdata, e_rdata, mem_wdata, mem_rdata;
    logic          c_gnt, e_gnt, c_rvalid, e_rvalid, mem_wr;
    logic [15:0]   c_wait_cnt, e_wait_cnt;
    modport slave (
        input  c_req, c_wr, c_addr, c_wdata, e_req, e_wr, e_addr, e_wdata, e_lock, mem_rdata,
        output c_gnt, e_gnt, c_rvalid, e_rvalid, c_rdata, e_rdata, mem_addr, mem_wr, mem_wdata,
               c_wait_cnt, e_wait_cnt
    );
    modport master (
        output c_req, c_wr, c_addr, c_wdata, e_req, e_wr, e_addr, e_wdata, e_lock, mem_rdata,
        input  c_gnt, e_gnt, c_rvalid, e_rvalid, c_rdata, e_rdata, mem_addr, mem_wr, mem_wdata,
               c_wait_cnt, e_wait_cnt
    );
endinterface

// File: rtl/dmem_arb_sat_cnt.sv
// dmem_arb_sat_cnt: 16-bit counter that increments on inc and sticks at 16'hFFFF
// clk/reset : clock, async active-high reset
// inc       : count this cycle
// cnt       : current count
module dmem_arb_sat_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] cnt
);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between processor port C and loader/debug port E
// clk/reset : clock, async active-high reset
// bus       : dmem_arbiter_if.slave (requests, grants, 1-cycle read return, dmem strobes, stats)
// DMEM_ARB_STATS_EN : when defined, per-port saturating wait-cycle counters; otherwise they read 0
module dmem_arbiter
    import dsd_mem_pkg::*;
#(
    parameter int MAX_LOCK = 8,
    parameter int AW       = 16,
    parameter int DW       = 16
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_LOCK + 2);
    arb_state_t    st, st_n;
    arb_port_t     last;
    logic [CW-1:0] lock_cnt, lock_cnt_n;
    logic [AW-1:0] addr_q, gnt_addr, word_addr;
    logic          c_gnt, e_gnt, rd_c, rd_e;
    logic [15:0]   c_wait, e_wait;
    always_comb begin
        c_gnt = 1'b0;
        e_gnt = 1'b0;
        case (st)
            FORCE_C: c_gnt = bus.c_req;
            LOCK: begin
                e_gnt = bus.e_req;
                c_gnt = bus.c_req & ~bus.e_req;
            end
            default: begin
                c_gnt = bus.c_req & (~bus.e_req | last == PORT_E);
                e_gnt = bus.e_req & (~bus.c_req | last == PORT_C);
            end
        endcase
    end
    // The lock budget is judged on the count including this cycle's grant, so
    // C is forced in right after the MAX_LOCK-th E grant it waited through.
    always_comb begin
        st_n       = st;
        lock_cnt_n = lock_cnt;
        case (st)
            RR: if (bus.e_lock && e_gnt) begin
                lock_cnt_n = CW'(1);
                st_n       = (bus.c_req && MAX_LOCK <= 1) ? FORCE_C : LOCK;
            end
            LOCK: begin
                if (e_gnt && bus.c_req) lock_cnt_n = lock_cnt + CW'(1);
                if (!bus.e_lock) st_n = RR;
                else if (bus.c_req && lock_cnt_n >= CW'(MAX_LOCK)) st_n = FORCE_C;
            end
            default: begin
                st_n       = bus.e_lock ? LOCK : RR;
                lock_cnt_n = '0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            st       <= RR;
            last     <= PORT_E;
            lock_cnt <= '0;
            addr_q   <= '0;
            rd_c     <= 1'b0;
            rd_e     <= 1'b0;
        end else begin
            st       <= st_n;
            lock_cnt <= lock_cnt_n;
            if (c_gnt) last <= PORT_C;
            else if (e_gnt) last <= PORT_E;
            if (c_gnt | e_gnt) addr_q <= word_addr;
            rd_c <= c_gnt & ~bus.c_wr;
            rd_e <= e_gnt & ~bus.e_wr;
        end
    assign gnt_addr      = e_gnt ? bus.e_addr : bus.c_addr;
    assign word_addr     = {2'b00, gnt_addr[AW-1:2]};
    assign bus.c_gnt     = c_gnt;
    assign bus.e_gnt     = e_gnt;
    assign bus.mem_addr  = (c_gnt | e_gnt) ? word_addr : addr_q;
    assign bus.mem_wr    = (c_gnt & bus.c_wr) | (e_gnt & bus.e_wr);
    assign bus.mem_wdata = e_gnt ? bus.e_wdata : c_gnt ? bus.c_wdata : '0;
    assign bus.c_rvalid  = rd_c;
    assign bus.e_rvalid  = rd_e;
    assign bus.c_rdata   = rd_c ? bus.mem_rdata : '0;
    assign bus.e_rdata   = rd_e ? bus.mem_rdata : '0;
`ifdef DMEM_ARB_STATS_EN
    dmem_arb_sat_cnt u_c_wait (.clk(clk), .reset(reset), .inc(bus.c_req & ~c_gnt), .cnt(c_wait));
    dmem_arb_sat_cnt u_e_wait (.clk(clk), .reset(reset), .inc(bus.e_req & ~e_gnt), .cnt(e_wait));
`else
    assign c_wait = '0;
    assign e_wait = '0;
`endif
    assign bus.c_wait_cnt = c_wait;
    assign bus.e_wait_cnt = e_wait;
endmodule
